// File: rtl/cntr_pkg.sv
// Shared constants and helpers for the up/down counter slice.
package cntr_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Terminal value for a direction: MODULUS-1 counting up, 0 counting down.
  function automatic logic [32:0] term_val(input logic dir, input logic [32:0] modulus);
    logic [32:0] tv;
    if (dir == DIR_UP) begin
      tv = modulus - 33'd1;
    end else begin
      tv = 33'd0;
    end
    return tv;
  endfunction

endpackage

// File: rtl/cntr_tc_det.sv
// Combinational terminal-value compare, shared by the cascade output and next-state logic.
module cntr_tc_det
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter logic [32:0] MODULUS = 33'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 33'd1);

  logic [WIDTH-1:0] term_s;

  // Select the terminal value for the current direction.
  always_comb begin
    term_s = '0;
    if (up == DIR_UP) begin
      term_s = MAX_Q;
    end else begin
      term_s = WIDTH'(term_val(DIR_DN, MODULUS));
    end
  end

  assign at_term = (q == term_s);

endmodule

// File: rtl/cntr_updn_mod.sv
// Modulo-N up/down counter with load, clear, preset, ripple cascade and optional one-shot stop.
module cntr_updn_mod
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic [32:0] MODULUS  = 33'd1 << WIDTH,
  parameter bit          ONE_SHOT = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  input  logic             EN,
  input  logic             CAI,
  input  logic             UP,
  input  logic             CS,
  input  logic             SD,
  output logic [WIDTH-1:0] Q,
  output logic             CAO,
  output logic             TC,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 33'd1);

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic             done_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             tc_nxt_s;
  logic             done_nxt_s;
  logic             at_term_s;
  logic             cnt_ok_s;
  logic             step_s;

  cntr_tc_det #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc_det (
    .q       (q_r),
    .up      (UP),
    .at_term (at_term_s)
  );

  assign cnt_ok_s = CAI & EN & ~done_r;
  assign step_s   = cnt_ok_s & ~CS & ~SD & ~LD;

  // Next state with priority CS > SD > LD > step > hold; RST is applied in the register.
  always_comb begin
    q_nxt_s    = q_r;
    tc_nxt_s   = 1'b0;
    done_nxt_s = done_r;
    if (CS) begin
      q_nxt_s    = '0;
      done_nxt_s = 1'b0;
    end else if (SD) begin
      q_nxt_s    = MAX_Q;
      done_nxt_s = 1'b0;
    end else if (LD) begin
      // Zero-extend before comparing so no width ever sees an overflow.
      if ({{(33 - WIDTH){1'b0}}, D} >= MODULUS) begin
        q_nxt_s = MAX_Q;
      end else begin
        q_nxt_s = D;
      end
      done_nxt_s = 1'b0;
    end else if (step_s) begin
      tc_nxt_s = at_term_s;
      if (at_term_s) begin
        if (ONE_SHOT) begin
          done_nxt_s = 1'b1;
        end else if (UP == DIR_UP) begin
          q_nxt_s = '0;
        end else begin
          q_nxt_s = MAX_Q;
        end
      end else if (UP == DIR_UP) begin
        q_nxt_s = q_r + WIDTH'(1'b1);
      end else begin
        q_nxt_s = q_r - WIDTH'(1'b1);
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_r    <= '0;
      tc_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      tc_r   <= tc_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Carry/borrow out stays combinational so ripple cascades settle in one cycle.
  assign CAO  = cnt_ok_s & at_term_s;
  assign Q    = q_r;
  assign TC   = tc_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_cntr_updn_mod.sv
// Scoreboard bench: wrap, one-shot and two-stage cascade counters against an arithmetic model.
module tb_cntr_updn_mod;

  localparam int M = 10;

  logic       CLK = 1'b0;
  logic       rst = 1'b1, ld = 1'b0, en = 1'b0, cai = 1'b0, up = 1'b1, cs = 1'b0, sd = 1'b0;
  logic [3:0] d = 4'd0;
  logic       c_rst = 1'b1, c_en = 1'b0;

  logic [3:0] q0, q1, clo, chi;
  logic       cao0, tc0, dn0, cao1, tc1, dn1;
  logic       lo_cao, lo_tc, lo_dn, hi_cao, hi_tc, hi_dn;

  always #5 CLK = ~CLK;

  cntr_updn_mod #(.WIDTH(4), .MODULUS(33'd10), .ONE_SHOT(1'b0)) dut_wrap (
    .CLK(CLK), .RST(rst), .D(d), .LD(ld), .EN(en), .CAI(cai), .UP(up), .CS(cs), .SD(sd),
    .Q(q0), .CAO(cao0), .TC(tc0), .DONE(dn0));

  cntr_updn_mod #(.WIDTH(4), .MODULUS(33'd10), .ONE_SHOT(1'b1)) dut_os (
    .CLK(CLK), .RST(rst), .D(d), .LD(ld), .EN(en), .CAI(cai), .UP(up), .CS(cs), .SD(sd),
    .Q(q1), .CAO(cao1), .TC(tc1), .DONE(dn1));

  cntr_updn_mod #(.WIDTH(4), .MODULUS(33'd10), .ONE_SHOT(1'b0)) dut_lo (
    .CLK(CLK), .RST(c_rst), .D(4'd0), .LD(1'b0), .EN(c_en), .CAI(c_en), .UP(1'b1), .CS(1'b0),
    .SD(1'b0), .Q(clo), .CAO(lo_cao), .TC(lo_tc), .DONE(lo_dn));

  cntr_updn_mod #(.WIDTH(4), .MODULUS(33'd10), .ONE_SHOT(1'b0)) dut_hi (
    .CLK(CLK), .RST(c_rst), .D(4'd0), .LD(1'b0), .EN(1'b1), .CAI(lo_cao), .UP(1'b1), .CS(1'b0),
    .SD(1'b0), .Q(chi), .CAO(hi_cao), .TC(hi_tc), .DONE(hi_dn));

  typedef struct {
    int q0, tc0, dn0, cao0;
    int q1, tc1, dn1, cao1;
    int clo, chi, ctc, lcao, hcao;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   drv_done = 1'b0;

  // Reference model state: plain integers
  int m_q0 = 0, m_dn0 = 0, m_q1 = 0, m_dn1 = 0, m_cn = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One counter instance, behavioural: returns next count/TC/DONE and current CAO.
  task automatic model(input int q, input int dn, input bit os, output int nq, output int ntc,
                       output int ndn, output int cao);
    bool_term: begin end
    cao = (cai && en && dn == 0 && (up ? q == M - 1 : q == 0)) ? 1 : 0;
    nq = q; ntc = 0; ndn = dn;
    if (rst) begin
      nq = 0; ndn = 0;
    end else if (cs) begin
      nq = 0; ndn = 0;
    end else if (sd) begin
      nq = M - 1; ndn = 0;
    end else if (ld) begin
      nq = (int'(d) > M - 1) ? M - 1 : int'(d); ndn = 0;
    end else if (cai && en && dn == 0) begin
      ntc = (up ? q == M - 1 : q == 0) ? 1 : 0;
      if (ntc == 1 && os) ndn = 1;
      else nq = up ? (q + 1) % M : (q + M - 1) % M;
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input bit ci, input bit u,
                       input bit c, input bit s, input logic [3:0] dd, input bit cr, input bit ce);
    exp_t x;
    int   nq, ntc, ndn, cao;
    @(negedge CLK);
    rst = r; ld = l; en = e; cai = ci; up = u; cs = c; sd = s; d = dd; c_rst = cr; c_en = ce;
    model(m_q0, m_dn0, 1'b0, nq, ntc, ndn, cao);
    x.q0 = nq; x.tc0 = ntc; x.dn0 = ndn; x.cao0 = cao; m_q0 = nq; m_dn0 = ndn;
    model(m_q1, m_dn1, 1'b1, nq, ntc, ndn, cao);
    x.q1 = nq; x.tc1 = ntc; x.dn1 = ndn; x.cao1 = cao; m_q1 = nq; m_dn1 = ndn;
    // Cascade viewed as a single decimal count 0..99
    x.lcao = (ce && m_cn % 10 == 9) ? 1 : 0;
    x.hcao = (ce && m_cn == 99) ? 1 : 0;
    x.ctc  = (!cr && ce && m_cn == 99) ? 1 : 0;
    m_cn   = cr ? 0 : (ce ? (m_cn + 1) % 100 : m_cn);
    x.clo = m_cn % 10; x.chi = m_cn / 10;
    sb.push_back(x);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (sb.size() != 0) begin
        e = sb[0];
        chk("cao_wrap", int'(cao0), e.cao0);
        chk("cao_os", int'(cao1), e.cao1);
        chk("cao_lo", int'(lo_cao), e.lcao);
        chk("cao_hi", int'(hi_cao), e.hcao);
      end
      @(posedge CLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("q_wrap", int'(q0), e.q0);
        chk("tc_wrap", int'(tc0), e.tc0);
        chk("done_wrap", int'(dn0), e.dn0);
        chk("q_os", int'(q1), e.q1);
        chk("tc_os", int'(tc1), e.tc1);
        chk("done_os", int'(dn1), e.dn1);
        chk("q_casc_lo", int'(clo), e.clo);
        chk("q_casc_hi", int'(chi), e.chi);
        chk("tc_casc_hi", int'(hi_tc), e.ctc);
      end
    end
  end

  initial begin
    // Reset with counting disabled, then release
    drive(1, 0, 0, 0, 1, 0, 0, 4'd0, 1, 0);
    drive(1, 0, 0, 0, 1, 0, 0, 4'd0, 1, 0);
    // Count up 12 cycles: 0..9, wrap
    for (int i = 0; i < 12; i++) drive(0, 0, 1, 1, 1, 0, 0, 4'd0, 0, 1);
    // Load 3 then count down through zero
    drive(0, 1, 1, 1, 0, 0, 0, 4'd3, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0, 0, 0, 4'd0, 0, 1);
    // Clamped load, then CS beats SD
    drive(0, 1, 1, 1, 1, 0, 0, 4'hF, 0, 1);
    drive(0, 0, 1, 1, 1, 1, 1, 4'd0, 0, 1);
    // One-shot: from 8 up for 4 steps, then reload 2
    drive(0, 1, 1, 1, 1, 0, 0, 4'd8, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 1, 0, 0, 4'd0, 0, 1);
    drive(0, 1, 1, 1, 1, 0, 0, 4'd2, 0, 1);
    drive(0, 0, 1, 1, 1, 0, 0, 4'd0, 0, 1);
    // Reset mid-count at 6 with EN high, then resume
    drive(0, 0, 1, 1, 1, 1, 0, 4'd0, 0, 1);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 1, 1, 0, 0, 4'd0, 0, 1);
    drive(1, 0, 1, 1, 1, 0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 1, 0, 0, 4'd0, 0, 1);
    // Extra stretch so the cascade crosses 99 -> 00 under plain counting
    for (int i = 0; i < 70; i++) drive(0, 0, 1, 1, 1, 0, 0, 4'd0, 0, 1);
    // Randomized traffic with rare control strobes
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0);
    end
    drv_done = 1'b1;
  end

  initial begin
    int waited = 0;
    wait (drv_done == 1'b1);
    while (sb.size() != 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cntr_updn_mod.md
CNTR_UPDN_MOD -- requirements
Module: cntr_updn_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter MODULUS, default 2**WIDTH: count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Parameter ONE_SHOT, default 0: 0 = wrap at terminal count, 1 = stop at terminal count.
REQ-004 The block SHALL have one clock, CLK; reset is RST, synchronous and active-high.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 D  input  WIDTH  parallel load data.
REQ-008 LD  input  1  synchronous parallel load.
REQ-009 EN  input  1  count enable.
REQ-010 CAI  input  1  cascade carry/borrow in.
REQ-011 UP  input  1  direction: 1 = up, 0 = down.
REQ-012 CS  input  1  synchronous clear to 0.
REQ-013 SD  input  1  synchronous preset to MODULUS-1.
REQ-014 Q  output  WIDTH  registered count.
REQ-015 CAO  output  1  combinational cascade carry/borrow out.
REQ-016 TC  output  1  registered terminal-count pulse.
REQ-017 DONE  output  1  registered sticky stop flag; used only when ONE_SHOT=1.

Function
REQ-018 Priority per edge SHALL be RST > CS > SD > LD > step > hold.
REQ-019 step SHALL be CAI & EN & ~DONE with CS, SD and LD all low.
REQ-020 Up step: Q<MODULUS-1 gives Q+1; Q==MODULUS-1 gives 0 (ONE_SHOT=0), or holds Q and sets DONE (ONE_SHOT=1).
REQ-021 Down step: Q>0 gives Q-1; Q==0 gives MODULUS-1 (ONE_SHOT=0), or holds Q and sets DONE (ONE_SHOT=1).
REQ-022 A step taken at the terminal value (MODULUS-1 up, 0 down) is a "terminal step".
REQ-023 TC SHALL be 1 for exactly the one cycle after each terminal step, otherwise 0.
REQ-024 CAO SHALL equal CAI & EN & ~DONE & (UP ? Q==MODULUS-1 : Q==0), with no register stage, so that ripple cascades work.
REQ-025 LD with D>MODULUS-1 SHALL load MODULUS-1 (clamp); otherwise Q=D.
REQ-026 LD, CS or SD SHALL clear DONE in the same edge.
REQ-027 UP may change on any cycle; the next step SHALL use the value sampled at that edge.
REQ-028 All arithmetic SHALL be modulo MODULUS, with no intermediate overflow beyond WIDTH bits.
REQ-029 Q SHALL never hold a value ≥ MODULUS.

Reset
REQ-030 RST=1 at an edge SHALL force Q=0, TC=0 and DONE=0, overriding all other inputs, including mid-count.
REQ-031 CAO SHALL be 0 whenever CAI=0 or EN=0, including during reset.

Structure
REQ-032 Package cntr_pkg SHALL hold the direction constants (DIR_UP=1, DIR_DN=0) and the function that computes the terminal value for a given direction and MODULUS.
REQ-033 A single sub-module, cntr_tc_det, SHALL perform the combinational terminal-value compare shared by CAO and next-state logic.
REQ-034 The design SHALL contain no latches, no asynchronous logic, and no second clock.

Verification (WIDTH=4, MODULUS=10)
REQ-035 RST then UP=1, EN=CAI=1 for 12 cycles -> Q=0..9,0,1; TC=1 only in the cycle Q first reads 0 after 9; CAO=1 while Q=9.
REQ-036 LD=1, D=3, then UP=0 for 5 steps -> Q=3,2,1,0,9,8; CAO=1 while Q=0.
REQ-037 LD=1 with D=4'hF -> Q=9 (clamp); SD=1 with CS=1 in the same cycle -> Q=0 (CS wins).
REQ-038 ONE_SHOT=1, UP=1 from Q=8 for 4 steps -> Q=9,9,9,9; DONE=1 from the cycle after the terminal step; CAO=0 once DONE=1; LD D=2 -> DONE=0, Q=2.
REQ-039 Two instances cascaded (CAO to CAI), counting up from 00 for 100 steps -> wraps to 00 at step 100; upper TC pulses once.
REQ-040 RST asserted mid-count at Q=6 with EN=1 -> Q=0 and TC=0 on the next edge; counting resumes from 0 after RST drops.
